// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite slot scheduler.
// Optional overlap detection is enabled with SPRITE_SCHED_COLLISION_EN.
`timescale 1ns/1ps
package sprite_sched_pkg;

    localparam logic [9:0] FRAME_X = 10'd0;
    localparam logic [9:0] FRAME_Y = 10'd480;
    localparam int         BASE_W  = 15;

    typedef enum logic [1:0] {
        F_X    = 2'd0,
        F_Y    = 2'd1,
        F_SIZE = 2'd2,
        F_BASE = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [7:0]        w;
        logic [7:0]        h;
        logic [BASE_W-1:0] base;
        logic              en;
    } slot_cfg_t;

endpackage

// File: rtl/sprite_slot_hit.sv
// Window compare and local ROM offset for one sprite slot.
// Sums are 11 bits wide so a window never wraps past column/row 1023.
`timescale 1ns/1ps
module sprite_slot_hit #(
    parameter int ADDR_W = 14
) (
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [7:0]        w,
    input  logic [7:0]        h,
    input  logic              en,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        in_x;
    logic        in_y;

    assign x_end = {1'b0, x} + {3'b0, w};
    assign y_end = {1'b0, y} + {3'b0, h};

    // A zero width/height makes x_end == x, so the window is empty.
    assign in_x = (draw_x >= x) && ({1'b0, draw_x} < x_end);
    assign in_y = (draw_y >= y) && ({1'b0, draw_y} < y_end);
    assign hit  = en && in_x && in_y;

    assign dx     = draw_x - x;
    assign dy     = draw_y - y;
    assign offset = ADDR_W'(dy) * ADDR_W'(w) + ADDR_W'(dx);

endmodule

// File: rtl/sprite_slot_scheduler.sv
// Shares one sprite ROM port among NUM_SLOTS prioritised screen slots.
// Define SPRITE_SCHED_COLLISION_EN to build the sticky overlap flag.
`timescale 1ns/1ps
module sprite_slot_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 14
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_slot,
    input  logic [1:0]        cfg_field,
    input  logic [15:0]       cfg_data,
    output logic              cfg_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              sel_valid,
    output logic [2:0]        sel_slot,
    output logic              collide
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIRTY  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]           state;
    slot_cfg_t            shadow [NUM_SLOTS];
    slot_cfg_t            active [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] hit;
    logic [ADDR_W-1:0]    offset [NUM_SLOTS];

    logic              wr_ok;
    logic              at_frame;
    logic              any_hit;
    logic [2:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic              hit_d;
    logic [2:0]        slot_d;

    assign cfg_ready = (state != S_COMMIT);
    assign wr_ok     = cfg_we && cfg_ready && (int'(cfg_slot) < NUM_SLOTS);
    assign at_frame  = (DrawX == FRAME_X) && (DrawY == FRAME_Y);

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        sprite_slot_hit #(
            .ADDR_W(ADDR_W)
        ) u_hit (
            .draw_x(DrawX),
            .draw_y(DrawY),
            .x     (active[i].x),
            .y     (active[i].y),
            .w     (active[i].w),
            .h     (active[i].h),
            .en    (active[i].en),
            .hit   (hit[i]),
            .offset(offset[i])
        );
    end

    // Scan from lowest priority up so the lowest index wins.
    always_comb begin
        win      = 3'd0;
        win_addr = rom_addr;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win      = 3'(i);
                win_addr = ADDR_W'(active[i].base + BASE_W'(offset[i]));
            end
        end
    end

    assign any_hit = blank && (|hit);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            unique case (1'b1)
                state == S_COMMIT:             state <= S_IDLE;
                state == S_DIRTY && at_frame:  state <= S_COMMIT;
                state == S_IDLE && wr_ok:      state <= S_DIRTY;
                default: ;
            endcase
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (state == S_COMMIT) begin
                    active[i] <= shadow[i];
                end
                if (wr_ok && cfg_slot == 3'(i)) begin
                    unique case (cfg_field_e'(cfg_field))
                        F_X:    shadow[i].x <= cfg_data[9:0];
                        F_Y:    shadow[i].y <= cfg_data[9:0];
                        F_SIZE: begin
                            shadow[i].w <= cfg_data[7:0];
                            shadow[i].h <= cfg_data[15:8];
                        end
                        F_BASE: begin
                            shadow[i].en   <= cfg_data[15];
                            shadow[i].base <= BASE_W'(cfg_data[ADDR_W-1:0]);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr  <= '0;
            hit_d     <= 1'b0;
            slot_d    <= 3'd0;
            sel_valid <= 1'b0;
            sel_slot  <= 3'd0;
        end else begin
            if (any_hit) begin
                rom_addr <= win_addr;
            end
            hit_d     <= any_hit;
            slot_d    <= any_hit ? win : 3'd0;
            sel_valid <= hit_d;
            sel_slot  <= slot_d;
        end
    end

`ifdef SPRITE_SCHED_COLLISION_EN
    logic multi;
    logic multi_d;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi = blank && ((hit & (hit - NUM_SLOTS'(1))) != '0);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            multi_d <= 1'b0;
            collide <= 1'b0;
        end else begin
            multi_d <= multi;
            if (state == S_COMMIT) begin
                collide <= 1'b0;
            end else if (multi_d) begin
                collide <= 1'b1;
            end
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_slot_scheduler.sv
// Directed scoreboard bench for sprite_slot_scheduler.
// Collision expectations follow SPRITE_SCHED_COLLISION_EN.
`timescale 1ns/1ps
module tb_sprite_slot_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        cfg_we;
    logic [2:0]  cfg_slot;
    logic [1:0]  cfg_field;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic [13:0] rom_addr;
    logic        sel_valid;
    logic [2:0]  sel_slot;
    logic        collide;

`ifdef SPRITE_SCHED_COLLISION_EN
    localparam logic COL_ON = 1'b1;
`else
    localparam logic COL_ON = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [2:0]  s;
        logic [13:0] a;
    } exp_t;

    exp_t        q[$];
    logic [13:0] last_addr;
    int          n_vec;
    int          n_bad;

    sprite_slot_scheduler #(
        .NUM_SLOTS(4),
        .ADDR_W   (14)
    ) dut (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .blank    (blank),
        .cfg_we   (cfg_we),
        .cfg_slot (cfg_slot),
        .cfg_field(cfg_field),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .rom_addr (rom_addr),
        .sel_valid(sel_valid),
        .sel_slot (sel_slot),
        .collide  (collide)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // rom_addr is checked one edge after sampling, sel_* one edge later.
    task automatic tick(input exp_t e);
        exp_t o;
        @(posedge vga_clk);
        #1;
        q.push_back(e);
        chk("rom_addr", 32'(rom_addr), 32'(e.a));
        if (q.size() > 1) begin
            o = q.pop_front();
            chk("sel_valid", 32'(sel_valid), 32'(o.v));
            chk("sel_slot", 32'(sel_slot), 32'(o.s));
        end
    endtask

    task automatic pix(input int x, input int y, input int b,
                       input int v, input int s, input int a);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = 1'(b);
        if (v != 0) last_addr = 14'(a);
        e.v = 1'(v);
        e.s = 3'(s);
        e.a = last_addr;
        tick(e);
    endtask

    task automatic idle();
        pix(0, 0, 0, 0, 0, 0);
    endtask

    task automatic boundary();
        pix(0, 480, 0, 0, 0, 0);
    endtask

    task automatic wr(input int slot, input int field, input int data);
        cfg_we    = 1'b1;
        cfg_slot  = 3'(slot);
        cfg_field = 2'(field);
        cfg_data  = 16'(data);
        idle();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        boundary();
        chk("ready_in_commit", 32'(cfg_ready), 32'(0));
        idle();
        chk("ready_after_commit", 32'(cfg_ready), 32'(1));
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        last_addr = '0;
        reset_n   = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        blank     = 1'b0;
        cfg_we    = 1'b0;
        cfg_slot  = '0;
        cfg_field = '0;
        cfg_data  = '0;
        #12;
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("rst_sel_valid", 32'(sel_valid), 32'(0));
        chk("rst_sel_slot", 32'(sel_slot), 32'(0));
        chk("rst_collide", 32'(collide), 32'(0));
        @(negedge vga_clk);
        reset_n = 1'b1;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));

        // slot 0: 40x40 at (299,434), base 0
        wr(0, 0, 299);
        wr(0, 1, 434);
        wr(0, 2, 16'h2828);
        wr(0, 3, 16'h8000);
        pix(300, 435, 1, 0, 0, 0);
        commit();
        pix(300, 435, 1, 1, 0, 41);
        pix(338, 434, 1, 1, 0, 39);
        pix(339, 434, 1, 0, 0, 0);
        pix(300, 435, 0, 0, 0, 0);
        idle();
        chk("collide_single", 32'(collide), 32'(0));

        // slot 1: 20x20 at (305,438), base 2000, overlaps slot 0
        wr(1, 0, 305);
        wr(1, 1, 438);
        wr(1, 2, 16'h1414);
        wr(1, 3, 16'h87D0);
        commit();
        pix(310, 440, 1, 1, 0, 251);
        idle();
        chk("collide_set", 32'(collide), 32'(COL_ON));
        idle();
        idle();
        chk("collide_hold", 32'(collide), 32'(COL_ON));
        wr(0, 3, 16'h0000);
        chk("collide_hold_dirty", 32'(collide), 32'(COL_ON));
        commit();
        chk("collide_clear", 32'(collide), 32'(0));
        pix(310, 440, 1, 1, 1, 2045);
        idle();
        chk("collide_after", 32'(collide), 32'(0));

        // slot 2 written mid-frame stays invisible until the boundary
        wr(2, 0, 100);
        wr(2, 1, 100);
        wr(2, 2, 16'h0808);
        wr(2, 3, 16'h81F4);
        pix(101, 101, 1, 0, 0, 0);
        boundary();
        chk("ready_boundary", 32'(cfg_ready), 32'(0));
        cfg_we    = 1'b1;
        cfg_slot  = 3'd2;
        cfg_field = 2'd3;
        cfg_data  = 16'h0000;
        idle();
        cfg_we = 1'b0;
        chk("ready_one_cycle", 32'(cfg_ready), 32'(1));
        pix(101, 101, 1, 1, 2, 509);
        boundary();
        chk("ready_idle_frame", 32'(cfg_ready), 32'(1));
        idle();
        wr(5, 3, 16'h8000);
        boundary();
        chk("ready_bad_slot", 32'(cfg_ready), 32'(1));
        idle();

        // slot 3 commit also proves the dropped slot 2 write never landed
        wr(3, 0, 0);
        wr(3, 1, 0);
        wr(3, 2, 16'h0404);
        wr(3, 3, 16'h812C);
        commit();
        pix(1, 1, 1, 1, 3, 305);
        pix(101, 101, 1, 1, 2, 509);
        idle();

        // reset while a shadow write is pending
        pix(101, 101, 1, 1, 2, 509);
        wr(3, 3, 16'h0000);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'(0));
        chk("mid_rst_sel_valid", 32'(sel_valid), 32'(0));
        chk("mid_rst_sel_slot", 32'(sel_slot), 32'(0));
        chk("mid_rst_collide", 32'(collide), 32'(0));
        chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'(1));
        @(negedge vga_clk);
        reset_n = 1'b1;
        q.delete();
        last_addr = '0;
        boundary();
        chk("ready_after_rst", 32'(cfg_ready), 32'(1));
        idle();
        pix(1, 1, 1, 0, 0, 0);
        pix(101, 101, 1, 0, 0, 0);
        pix(310, 440, 1, 0, 0, 0);
        idle();
        idle();
        chk("collide_after_rst", 32'(collide), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
